// File: rtl/internal_framebuffer_stream_loader.sv
// Loads an AXI-Stream of pixel beats into an internal framebuffer RAM through a
// registered write port, flagging streams whose tlast disagrees with the commanded size.
module internal_framebuffer_stream_loader #(
    parameter int NUMBER_OF_PIXELS_PER_BEAT    = 1,
    parameter int NUMBER_OF_SUB_PIXELS         = 4,
    parameter int SUB_PIXEL_WIDTH              = 8,
    parameter int FRAMEBUFFER_SIZE_IN_PIXEL_LG = 18,
    parameter int FB_SIZE_IN_PIXEL_LG          = 20,
    localparam int PW     = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
    localparam int SW     = NUMBER_OF_PIXELS_PER_BEAT * PW,
    localparam int MW     = NUMBER_OF_PIXELS_PER_BEAT * NUMBER_OF_SUB_PIXELS,
    localparam int PPB_LG = $clog2(NUMBER_OF_PIXELS_PER_BEAT),
    localparam int AW     = FRAMEBUFFER_SIZE_IN_PIXEL_LG - PPB_LG
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUMBER_OF_SUB_PIXELS-1:0] confMask,
    input  logic                            apply,
    output logic                            applied,
    input  logic                            cmdLoad,
    input  logic [FB_SIZE_IN_PIXEL_LG-1:0]  cmdSize,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic [SW-1:0]                   s_axis_tdata,
    output logic [SW-1:0]                   writeDataPort,
    output logic                            writeEnablePort,
    output logic [AW-1:0]                   writeAddrPort,
    output logic [MW-1:0]                   writeMaskPort,
    output logic                            loadError,
    output logic [1:0]                      debugState
);

    // Stream handshake: a beat transfers on a rising edge where s_axis_tvalid and
    // s_axis_tready are both high; tready is a flop that is high only in LOAD/DRAIN.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [AW-1:0] ONE = 1;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] index_q, index_d;
    logic [AW-1:0] size_q, size_d;
    logic          error_q, error_d;
    logic          applied_q, applied_d;
    logic          tready_q, tready_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [SW-1:0] data_q, data_d;
    logic [MW-1:0] mask_q, mask_d;

    logic          accept;
    logic [AW-1:0] cmd_beats;
    logic          cmd_size_unused;

    assign accept          = s_axis_tvalid && tready_q;
    assign cmd_beats       = cmdSize[PPB_LG +: AW];
    assign cmd_size_unused = ^cmdSize;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        size_d  = size_q;
        error_d = error_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;

        case (state_q)
            ST_IDLE: begin
                index_d = '0;
                if (apply && cmdLoad) begin
                    error_d = 1'b0;
                    size_d  = cmd_beats;
                    if (cmd_beats != '0) begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = index_q;
                    data_d  = s_axis_tdata;
                    mask_d  = {NUMBER_OF_PIXELS_PER_BEAT{confMask}};
                    index_d = index_q + ONE;
                    // Final commanded beat: a missing tlast leaves the rest of the packet to drain.
                    if (index_q == size_q - ONE) begin
                        if (s_axis_tlast) begin
                            state_d = ST_IDLE;
                        end else begin
                            error_d = 1'b1;
                            state_d = ST_DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        applied_d = (state_d == ST_IDLE) && !((state_q == ST_IDLE) && apply);
        tready_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            index_q   <= '0;
            size_q    <= '0;
            error_q   <= 1'b0;
            applied_q <= 1'b1;
            tready_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            size_q    <= size_d;
            error_q   <= error_d;
            applied_q <= applied_d;
            tready_q  <= tready_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
        end
    end

    assign applied         = applied_q;
    assign s_axis_tready   = tready_q;
    assign writeEnablePort = we_q;
    assign writeAddrPort   = addr_q;
    assign writeDataPort   = data_q;
    assign writeMaskPort   = mask_q;
    assign loadError       = error_q;
    assign debugState      = state_q;

endmodule

// File: tb/tb_internal_framebuffer_stream_loader.sv
// Bench for the framebuffer stream loader: directed and randomized loads on a
// one-pixel-per-beat instance, plus a two-pixel-per-beat instance for mask replication.
module tb_internal_framebuffer_stream_loader;

    localparam int A_SW = 32;
    localparam int A_AW = 18;
    localparam int A_MW = 4;
    localparam int B_SW = 64;
    localparam int B_AW = 17;
    localparam int B_MW = 8;
    localparam int SB_W = A_AW + A_SW + A_MW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // instance A: one pixel per beat
    logic [3:0]      a_mask = '0;
    logic            a_apply = 1'b0, a_applied, a_cmd_load = 1'b0;
    logic [19:0]     a_cmd_size = '0;
    logic            a_tvalid = 1'b0, a_tready, a_tlast = 1'b0;
    logic [A_SW-1:0] a_tdata = '0, a_wdata;
    logic            a_we, a_err;
    logic [A_AW-1:0] a_waddr;
    logic [A_MW-1:0] a_wmask;
    logic [1:0]      a_state;

    // instance B: two pixels per beat
    logic [3:0]      b_mask = '0;
    logic            b_apply = 1'b0, b_applied, b_cmd_load = 1'b0;
    logic [19:0]     b_cmd_size = '0;
    logic            b_tvalid = 1'b0, b_tready, b_tlast = 1'b0;
    logic [B_SW-1:0] b_tdata = '0, b_wdata;
    logic            b_we, b_err;
    logic [B_AW-1:0] b_waddr;
    logic [B_MW-1:0] b_wmask;
    logic [1:0]      b_state;

    internal_framebuffer_stream_loader dut_a (
        .clk(clk), .reset(reset), .confMask(a_mask), .apply(a_apply), .applied(a_applied),
        .cmdLoad(a_cmd_load), .cmdSize(a_cmd_size), .s_axis_tvalid(a_tvalid),
        .s_axis_tready(a_tready), .s_axis_tlast(a_tlast), .s_axis_tdata(a_tdata),
        .writeDataPort(a_wdata), .writeEnablePort(a_we), .writeAddrPort(a_waddr),
        .writeMaskPort(a_wmask), .loadError(a_err), .debugState(a_state)
    );

    internal_framebuffer_stream_loader #(.NUMBER_OF_PIXELS_PER_BEAT(2)) dut_b (
        .clk(clk), .reset(reset), .confMask(b_mask), .apply(b_apply), .applied(b_applied),
        .cmdLoad(b_cmd_load), .cmdSize(b_cmd_size), .s_axis_tvalid(b_tvalid),
        .s_axis_tready(b_tready), .s_axis_tlast(b_tlast), .s_axis_tdata(b_tdata),
        .writeDataPort(b_wdata), .writeEnablePort(b_we), .writeAddrPort(b_waddr),
        .writeMaskPort(b_wmask), .loadError(b_err), .debugState(b_state)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [SB_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected behaviour from the transfer rules: beats up to and including the
    // first tlast are accepted; the first min(size, tlast_pos+1) of them are written
    // to addresses 0,1,...; the error flag is set unless tlast is on beat size-1.
    task automatic run_load(input int n, input int tl_pos, input int gap_max,
                            input int abort_after, input logic [3:0] mask);
        int n_wr, n_send, gaps, wait_cnt;
        logic t;
        logic [A_SW-1:0] d;
        logic [SB_W-1:0] e;
        logic [A_AW-1:0] k_addr;
        n_wr   = (n < tl_pos + 1) ? n : tl_pos + 1;
        n_send = (abort_after >= 0) ? abort_after : tl_pos + 1;
        a_mask = mask;
        a_apply = 1'b1; a_cmd_load = 1'b1; a_cmd_size = n[19:0];
        step();
        a_apply = 1'b0;
        check("tready_after_apply", a_tready, (n != 0));
        check("applied_low_after_apply", a_applied, 1'b0);
        if (n == 0) begin
            step();
            check("zero_size_applied", a_applied, 1'b1);
            check("zero_size_tready", a_tready, 1'b0);
            return;
        end
        for (int k = 0; k < n_send; k++) begin
            gaps = $urandom_range(0, gap_max);
            for (int g = 0; g < gaps; g++) begin
                a_tvalid = 1'b0;
                a_apply = 1'($urandom_range(0, 1));
                a_cmd_size = 20'($urandom);
                step();
                check("stall_no_write", a_we, 1'b0);
                check("stall_tready_hold", a_tready, 1'b1);
            end
            a_apply = 1'b0;
            d = $urandom;
            a_tdata = d; a_tvalid = 1'b1; a_tlast = (k == tl_pos);
            k_addr = A_AW'(k);
            if (k < n_wr) exp_q.push_back({k_addr, d, mask});
            wait_cnt = 0;
            do begin
                t = a_tready;
                step();
                wait_cnt++;
            end while (!t && wait_cnt < 16);
            check("accept_timeout", t, 1'b1);
            a_tvalid = 1'b0; a_tlast = 1'b0;
            if (k < n_wr) begin
                check("write_enable", a_we, 1'b1);
                e = exp_q.pop_front();
                check("write_addr_data_mask", {a_waddr, a_wdata, a_wmask}, e);
            end else begin
                check("drain_no_write", a_we, 1'b0);
            end
        end
        if (abort_after >= 0) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            check("abort_tready", a_tready, 1'b0);
            check("abort_we", a_we, 1'b0);
            check("abort_applied", a_applied, 1'b1);
            check("abort_error", a_err, 1'b0);
            return;
        end
        step();
        check("end_tready", a_tready, 1'b0);
        check("end_we", a_we, 1'b0);
        check("end_load_error", a_err, (tl_pos != n - 1));
        check("end_applied", a_applied, 1'b1);
    endtask

    // Two pixels per beat: size in pixels halves into beats, mask repeats per pixel.
    task automatic run_b(input int size_px, input logic [3:0] mask);
        int beats;
        logic [B_SW-1:0] d;
        beats = size_px / 2;
        b_mask = mask;
        b_apply = 1'b1; b_cmd_load = 1'b1; b_cmd_size = size_px[19:0];
        step();
        b_apply = 1'b0;
        check("b_tready_after_apply", b_tready, 1'b1);
        for (int k = 0; k < beats; k++) begin
            d = {$urandom, $urandom};
            b_tdata = d; b_tvalid = 1'b1; b_tlast = (k == beats - 1);
            step();
            b_tvalid = 1'b0; b_tlast = 1'b0;
            check("b_write_enable", b_we, 1'b1);
            check("b_write_addr", 64'(b_waddr), 64'(k));
            check("b_write_data", b_wdata, d);
            check("b_write_mask", 64'(b_wmask), 64'({mask, mask}));
        end
        step();
        check("b_end_tready", b_tready, 1'b0);
        check("b_end_error", b_err, 1'b0);
        check("b_end_applied", b_applied, 1'b1);
    endtask

    initial begin
        int n, tl;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_applied", a_applied, 1'b1);
        check("reset_tready", a_tready, 1'b0);
        check("reset_we", a_we, 1'b0);
        check("reset_error", a_err, 1'b0);

        run_load(4, 3, 0, -1, 4'hF);
        run_b(8, 4'b0111);
        run_load(4, 1, 0, -1, 4'hF);
        run_load(2, 3, 0, -1, 4'hA);
        run_load(3, 2, 3, -1, 4'($urandom));

        // non-load command: applied drops for one cycle only
        a_apply = 1'b1; a_cmd_load = 1'b0; a_cmd_size = 20'd5;
        step();
        a_apply = 1'b0;
        check("noop_applied_low", a_applied, 1'b0);
        check("noop_tready", a_tready, 1'b0);
        step();
        check("noop_applied_back", a_applied, 1'b1);
        check("noop_no_write", a_we, 1'b0);

        run_load(0, 0, 0, -1, 4'hF);
        run_load(4, 3, 1, 2, 4'hF);
        run_load(1, 0, 0, -1, 4'hF);

        for (int r = 0; r < 8; r++) begin
            n  = $urandom_range(1, 6);
            tl = $urandom_range(0, n + 2);
            run_load(n, tl, 3, -1, 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/internal_framebuffer_stream_loader.md
INTERNAL_FRAMEBUFFER_STREAM_LOADER -- requirements
Module: internal_framebuffer_stream_loader

Interface
REQ-001 SHALL have parameter NUMBER_OF_PIXELS_PER_BEAT, default 1, pixels per stream beat and per memory word; power of two.
REQ-002 SHALL have parameter NUMBER_OF_SUB_PIXELS, default 4, sub pixels per pixel.
REQ-003 SHALL have parameter SUB_PIXEL_WIDTH, default 8, bits per sub pixel.
REQ-004 SHALL have parameter FRAMEBUFFER_SIZE_IN_PIXEL_LG, default 18, log2 of memory size in pixels.
REQ-005 SHALL have parameter FB_SIZE_IN_PIXEL_LG, default 20, width of cmdSize.
REQ-006 Derived widths: PW=NUMBER_OF_SUB_PIXELS*SUB_PIXEL_WIDTH; SW=NUMBER_OF_PIXELS_PER_BEAT*PW; MW=NUMBER_OF_PIXELS_PER_BEAT*NUMBER_OF_SUB_PIXELS; AW=FRAMEBUFFER_SIZE_IN_PIXEL_LG-log2(NUMBER_OF_PIXELS_PER_BEAT).
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 reset  in  1  reset, synchronous, active-high.
REQ-009 confMask  in  NUMBER_OF_SUB_PIXELS  per-sub-pixel write enable.
REQ-010 apply  in  1  start command; applied  out  1  high when idle and no command pending.
REQ-011 cmdLoad  in  1  load command select; cmdSize  in  FB_SIZE_IN_PIXEL_LG  transfer size in pixels.
REQ-012 s_axis_tvalid in 1, s_axis_tready out 1, s_axis_tlast in 1, s_axis_tdata in SW: AXI-Stream slave, pixel 0 in LSBs.
REQ-013 writeDataPort out SW, writeEnablePort out 1, writeAddrPort out AW, writeMaskPort out MW: registered RAM write port.
REQ-014 loadError  out  1  sticky: stream tlast did not coincide with final beat.

Function
REQ-015 States: IDLE, LOAD, DRAIN.
REQ-016 IDLE: applied=1 when apply=0; s_axis_tready=0; beat index cleared to 0.
REQ-017 IDLE with apply=1 and cmdLoad=1: applied<=0, loadError<=0, sizeBeats<=cmdSize[log2(PPB) +: AW]; next state LOAD if sizeBeats!=0, else stay IDLE (applied returns 1 next cycle when apply low).
REQ-018 IDLE with apply=1 and cmdLoad=0: applied<=0 for one cycle, no other effect.
REQ-019 s_axis_tready SHALL be registered, 1 exactly while in LOAD or DRAIN.
REQ-020 Beat accepted when tvalid&&tready; no acceptance in any other cycle.
REQ-021 LOAD accept: one cycle later writeEnablePort=1, writeAddrPort=index, writeDataPort=tdata, writeMaskPort=confMask replicated per pixel; index<=index+1 (AW bits, wraps).
REQ-022 writeEnablePort SHALL be 0 in every cycle not following a LOAD accept; DRAIN beats never written.
REQ-023 LOAD accept with index==sizeBeats-1 and tlast=1: next state IDLE.
REQ-024 LOAD accept with index==sizeBeats-1 and tlast=0: loadError<=1, next state DRAIN.
REQ-025 LOAD accept with tlast=1 and index<sizeBeats-1: beat written, loadError<=1, next state IDLE.
REQ-026 DRAIN: accept and discard beats; accept with tlast=1 -> IDLE.
REQ-027 apply while in LOAD or DRAIN SHALL be ignored; config inputs sampled live.
REQ-028 Stall (tvalid=0) in LOAD/DRAIN holds state, index and loadError indefinitely.

Reset
REQ-029 Reset: state IDLE, applied=1, s_axis_tready=0, writeEnablePort=0, loadError=0, index=0.
REQ-030 Reset mid-LOAD/DRAIN aborts transfer; no write in the cycle after reset; data/addr/mask outputs unspecified while writeEnablePort=0.

Verification
REQ-031 PPB=1, cmdSize=4, beats D0..D3 tlast on D3 -> writes addr 0..3 data D0..D3, mask 4'hF, loadError=0, applied=1 after.
REQ-032 PPB=2, cmdSize=8, confMask=4'b0111, 4 beats -> addr 0..3, writeMaskPort=8'h77 each write.
REQ-033 cmdSize=4, tlast on beat 2 -> writes addr 0,1, loadError=1, IDLE, tready=0.
REQ-034 cmdSize=2, tlast on beat 4 -> writes addr 0,1 only, beats 3,4 drained, loadError=1, then IDLE.
REQ-035 tvalid toggled 1,0,0,1 random during cmdSize=3 load -> exactly 3 writes in order, one cycle after each accept.
REQ-036 Reset asserted after 2 of 4 beats -> tready=0, writeEnablePort=0, applied=1 next cycle; new load of cmdSize=1 then writes addr 0.
